// File: rtl/layer_three_if.sv
// Bus between the top-level controller and the final BNN layer.
// The controller drives the FSM state, the binary feature map and the
// class weights. The layer returns the predicted digit, its score and a
// done flag.
interface layer_three_if #(
  parameter int N_CLASSES = 10,
  parameter int IN_BITS   = 196
);
  logic [2:0]                   state;
  logic [IN_BITS-1:0]           features;
  logic [N_CLASSES*IN_BITS-1:0] weights;
  logic [3:0]                   digit;
  logic [7:0]                   max_score;
  logic                         done;

  modport master (
    output state, features, weights,
    input  digit, max_score, done
  );

  modport slave (
    input  state, features, weights,
    output digit, max_score, done
  );
endinterface

// File: rtl/layer_three.sv
// Final BNN stage: XNOR-popcount fully-connected layer followed by an argmax.
// The 196-bit feature vector is scored against each class one 49-bit plane
// per cycle. Each class then gets one compare cycle. The winning class index
// and its score are published with done.
module layer_three #(
  parameter int N_CLASSES = 10,
  parameter int IN_BITS   = 196,
  parameter int CHUNK     = 49
) (
  input logic         clk,
  input logic         rst_n,
  layer_three_if.slave bus
);

  localparam int N_CHUNKS = IN_BITS / CHUNK;
  localparam int CLS_W    = $clog2(N_CLASSES);
  localparam int CHK_W    = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
  localparam int ACC_W    = $clog2(IN_BITS + 1);
  localparam int FI_W     = $clog2(IN_BITS);
  localparam int WI_W     = $clog2(N_CLASSES * IN_BITS);

  localparam logic [2:0] S_LAYER_3 = 3'b100;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACCUM   = 2'd1;
  localparam logic [1:0] ST_COMPARE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam logic [CLS_W-1:0] LAST_CLS   = CLS_W'(N_CLASSES - 1);
  localparam logic [CHK_W-1:0] LAST_CHUNK = CHK_W'(N_CHUNKS - 1);

  // Count of set bits in one plane-sized slice of the match vector.
  function automatic logic [ACC_W-1:0] popcount(input logic [CHUNK-1:0] v);
    logic [ACC_W-1:0] c;
    c = '0;
    for (int i = 0; i < CHUNK; i++) c = c + ACC_W'(v[i]);
    return c;
  endfunction

  logic [1:0]       fsm;
  logic [CLS_W-1:0] cls;
  logic [CHK_W-1:0] chunk;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] best_score;
  logic [CLS_W-1:0] best_cls;

  logic             active;
  logic [FI_W-1:0]  f_idx;
  logic [WI_W-1:0]  w_idx;
  logic [CHUNK-1:0] match;
  logic [ACC_W-1:0] chunk_pop;
  logic             take;
  logic [ACC_W-1:0] nxt_score;
  logic [CLS_W-1:0] nxt_cls;

  assign active = (bus.state == S_LAYER_3);

  // Slice the current plane and score it. The compare result is also
  // computed here, so the last class's update can go straight to the outputs.
  // Class 0 always seeds the best. Ties keep the earlier, lower class.
  always_comb begin
    f_idx     = FI_W'(chunk) * FI_W'(CHUNK);
    w_idx     = WI_W'(cls) * WI_W'(IN_BITS) + WI_W'(chunk) * WI_W'(CHUNK);
    match     = ~(bus.features[f_idx +: CHUNK] ^ bus.weights[w_idx +: CHUNK]);
    chunk_pop = popcount(match);
    take      = (cls == '0) || (acc > best_score);
    nxt_score = take ? acc : best_score;
    nxt_cls   = take ? cls : best_cls;
  end

  // Control FSM: accumulate 4 planes per class, compare, repeat, publish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm           <= ST_IDLE;
      cls           <= '0;
      chunk         <= '0;
      acc           <= '0;
      best_score    <= '0;
      best_cls      <= '0;
      bus.digit     <= '0;
      bus.max_score <= '0;
      bus.done      <= 1'b0;
    end else begin
      case (fsm)
        ST_IDLE: begin
          bus.done <= 1'b0;
          if (active) begin
            fsm        <= ST_ACCUM;
            cls        <= '0;
            chunk      <= '0;
            acc        <= '0;
            best_score <= '0;
            best_cls   <= '0;
          end
        end
        ST_ACCUM: begin
          if (!active) begin
            fsm <= ST_IDLE;
          end else begin
            acc <= acc + chunk_pop;
            if (chunk == LAST_CHUNK) begin
              chunk <= '0;
              fsm   <= ST_COMPARE;
            end else begin
              chunk <= chunk + CHK_W'(1);
            end
          end
        end
        ST_COMPARE: begin
          if (!active) begin
            fsm <= ST_IDLE;
          end else begin
            best_score <= nxt_score;
            best_cls   <= nxt_cls;
            if (cls == LAST_CLS) begin
              fsm           <= ST_DONE;
              bus.digit     <= nxt_cls;
              bus.max_score <= nxt_score;
              bus.done      <= 1'b1;
            end else begin
              cls <= cls + CLS_W'(1);
              acc <= '0;
              fsm <= ST_ACCUM;
            end
          end
        end
        default: begin
          if (!active) begin
            fsm      <= ST_IDLE;
            bus.done <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_layer_three.sv
// Directed bench for layer_three. A table of feature/weight sets with
// hand-computed argmax results is run first. Hand-written sequences then
// cover abort/restart and asynchronous reset.
module tb_layer_three;

  typedef struct {
    logic [195:0]  f;
    logic [1959:0] w;
    logic [3:0]    exp_digit;
    logic [7:0]    exp_score;
  } vec_t;

  logic clk;
  logic rst_n;

  layer_three_if #(.N_CLASSES(10), .IN_BITS(196)) bus ();

  layer_three dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [195:0] lowmask(input int n);
    logic [195:0] m;
    m = '0;
    for (int i = 0; i < n; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [195:0] rand_f();
    logic [195:0] f;
    for (int i = 0; i < 196; i++) f[i] = 1'($urandom_range(1, 0));
    return f;
  endfunction

  // Count edges until done rises. Returns -1 if it never does within the budget.
  task automatic wait_done(output int edges);
    edges = -1;
    for (int e = 1; e <= 120; e++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        edges = e;
        return;
      end
    end
  endtask

  task automatic run_vec(input int i);
    int edges;
    @(negedge clk);
    bus.features = vecs[i].f;
    bus.weights  = vecs[i].w;
    bus.state    = 3'b100;
    wait_done(edges);
    check($sformatf("v%0d_latency", i), edges, 51);
    check($sformatf("v%0d_digit", i), bus.digit, vecs[i].exp_digit);
    check($sformatf("v%0d_score", i), bus.max_score, vecs[i].exp_score);
    @(negedge clk);
    bus.state = 3'b000;
    @(posedge clk);
    #1;
    check($sformatf("v%0d_done_clear", i), bus.done, 0);
    check($sformatf("v%0d_digit_keep", i), bus.digit, vecs[i].exp_digit);
  endtask

  initial begin
    logic [195:0] f;
    logic [195:0] ones;
    logic [195:0] m;
    int           edges;
    int           early;

    ones = '1;
    rst_n = 1'b0;
    bus.state    = 3'b000;
    bus.features = '0;
    bus.weights  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_digit", bus.digit, 0);
    check("rst_score", bus.max_score, 0);
    check("rst_done", bus.done, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 0: every class is the exact complement, so all score 0 and class 0 wins.
    f = rand_f();
    vecs[0].f = f;
    for (int c = 0; c < 10; c++) vecs[0].w[c*196 +: 196] = ~f;
    vecs[0].exp_digit = 4'd0; vecs[0].exp_score = 8'd0;
    // 1: class 5 matches exactly and all others are complements.
    f = rand_f();
    vecs[1].f = f;
    for (int c = 0; c < 10; c++) vecs[1].w[c*196 +: 196] = (c == 5) ? f : ~f;
    vecs[1].exp_digit = 4'd5; vecs[1].exp_score = 8'd196;
    // 2: all zero, a ten-way tie at 196 that resolves to class 0.
    vecs[2].f = '0;
    vecs[2].w = '0;
    vecs[2].exp_digit = 4'd0; vecs[2].exp_score = 8'd196;
    // 3: classes 2 and 7 both miss 46 bits and class 4 misses 47 bits.
    f = rand_f();
    vecs[3].f = f;
    for (int c = 0; c < 10; c++) begin
      m = (c == 2 || c == 7) ? lowmask(46) : (c == 4) ? lowmask(47) : ones;
      vecs[3].w[c*196 +: 196] = f ^ m;
    end
    vecs[3].exp_digit = 4'd2; vecs[3].exp_score = 8'd150;
    // 4: class c misses 20-c bits, so the score rises with the class and 9 wins.
    f = rand_f();
    vecs[4].f = f;
    for (int c = 0; c < 10; c++) vecs[4].w[c*196 +: 196] = f ^ lowmask(20 - c);
    vecs[4].exp_digit = 4'd9; vecs[4].exp_score = 8'd185;
    // 5: chunk-boundary flips. Class 9 misses bit 195 and class 0 misses bits 48 and 49.
    f = rand_f();
    vecs[5].f = f;
    for (int c = 0; c < 10; c++) begin
      m = ones;
      if (c == 9) begin m = '0; m[195] = 1'b1; end
      if (c == 0) begin m = '0; m[48] = 1'b1; m[49] = 1'b1; end
      vecs[5].w[c*196 +: 196] = f ^ m;
    end
    vecs[5].exp_digit = 4'd9; vecs[5].exp_score = 8'd195;

    for (int i = 0; i < 6; i++) run_vec(i);

    // Abort on edge 20 while the previous result (9, 195) is still on the pins.
    @(negedge clk);
    bus.features = vecs[1].f;
    bus.weights  = vecs[1].w;
    bus.state    = 3'b100;
    early = 0;
    for (int e = 1; e <= 19; e++) begin
      @(posedge clk);
      #1;
      if (bus.done !== 1'b0) early++;
    end
    check("abort_pre_done", early, 0);
    @(negedge clk);
    bus.state = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    check("abort_done", bus.done, 0);
    check("abort_digit", bus.digit, 9);
    check("abort_score", bus.max_score, 195);
    @(negedge clk);
    bus.state = 3'b100;
    wait_done(edges);
    check("restart_latency", edges, 51);
    check("restart_digit", bus.digit, 5);
    check("restart_score", bus.max_score, 196);
    repeat (3) @(posedge clk);
    #1;
    check("done_hold", bus.done, 1);
    check("digit_hold", bus.digit, 5);

    // Asynchronous reset mid-ACCUM, with digit 5 still held from the last run.
    @(negedge clk);
    bus.state = 3'b000;
    @(negedge clk);
    bus.state = 3'b100;
    repeat (9) @(posedge clk);
    #3;
    check("pre_rst_digit", bus.digit, 5);
    rst_n = 1'b0;
    #1;
    check("arst_done", bus.done, 0);
    check("arst_digit", bus.digit, 0);
    check("arst_score", bus.max_score, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_done(edges);
    check("post_rst_latency", edges, 51);
    check("post_rst_digit", bus.digit, 5);
    check("post_rst_score", bus.max_score, 196);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/layer_three.md
Name: layer_three

Overview:
- Final BNN stage and consumer of the 4x7x7 binary map produced by layer two. It streams that 196-bit vector through a 10-class XNOR-popcount fully-connected layer and then takes the argmax.
- The result is the predicted MNIST digit, presented to the top-level output pins.
- Runs only while the top FSM holds `state == s_LAYER_3`, and raises `done` when the result is valid.

Parameters:
- `N_CLASSES`, 10, number of output classes/digits.
- `IN_BITS`, 196, length of the binary input vector (4 filters x 7 x 7).
- `CHUNK`, 49, bits processed per cycle (one 7x7 filter plane); `IN_BITS` must be a multiple of `CHUNK`.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `state` input 3: top-level FSM state; this block is active only when `state == 3'b100` (`s_LAYER_3`).
- `features` input 196: layer two output; bit index is `wn*49 + row*7 + col`. Held stable by the producer while `s_LAYER_3` is active.
- `weights` input 1960: class weights; bit index is `cls*196 + i`, paired with `features[i]`.
- `digit` output 4: argmax class index.
- `max_score` output 8: popcount of the winning class (0..196).
- `done` output 1: result valid.

Behaviour:
- Reset (asynchronous, any time, no clock needed):
  - FSM goes to IDLE.
  - `digit` = 0, `max_score` = 0, `done` = 0.
  - Internal `cls`, `chunk`, `acc`, `best_score`, `best_cls` all = 0.
- FSM states: IDLE, ACCUM, COMPARE, DONE. All state and output registers update on the rising edge.
- IDLE:
  - `done` = 0.
  - If `state == s_LAYER_3`: go to ACCUM with `cls` = 0, `chunk` = 0, `acc` = 0, `best_score` = 0, `best_cls` = 0.
- ACCUM (one edge per chunk):
  - `acc <= acc + popcount(~(features[chunk*49 +: 49] ^ weights[cls*196 + chunk*49 +: 49]))`.
  - Per-chunk popcount is 0..49; `acc` is 8 bits and never overflows (max 196).
  - `chunk` increments. The edge that processes chunk 3 moves to COMPARE with `chunk` = 0.
- COMPARE:
  - If `cls == 0` or `acc > best_score` (strictly greater), then `best_score <= acc` and `best_cls <= cls`.
  - Ties keep the lower class index.
  - If `cls == N_CLASSES-1`, go to DONE; on that same edge load `digit` with the final best class and `max_score` with the final best score (including this class's update), and set `done` = 1.
  - Otherwise `cls` increments, `acc` = 0, return to ACCUM.
- DONE:
  - `done`, `digit` and `max_score` hold while `state == s_LAYER_3`.
  - When `state != s_LAYER_3`: go to IDLE and clear `done`; `digit` and `max_score` retain their values.
- Latency:
  - Edge 1 is the first edge that samples `state == s_LAYER_3` (IDLE to ACCUM).
  - Each class then takes 5 edges (4 ACCUM + 1 COMPARE).
  - `done` rises after edge 51; `digit` and `max_score` are valid on the same edge.
- Abort: if `state` leaves `s_LAYER_3` while in ACCUM or COMPARE, the next edge goes to IDLE.
  - `done` stays 0; `digit` and `max_score` keep their previous values.
  - Partial results are discarded; re-entry restarts from class 0.
- Re-run: returning from DONE to IDLE and re-entering `s_LAYER_3` performs a full fresh 51-edge evaluation.
- Inputs are sampled combinationally each ACCUM cycle; no input capture register.

Test Plan:
- Exact match, latency:
  - Stimulus: `features` = random; class 5 weights = `features`; all other classes = `~features`; `state` = `3'b100`.
  - Response: `digit` = 5 and `max_score` = 196, with `done` first high after edge 51 and not before.
- All-zero tie: all `features` = 0, all `weights` = 0 -> every score is 196; `digit` = 0, `max_score` = 196.
- Two-way tie:
  - Stimulus: classes 2 and 7 each mismatch `features` in exactly 46 bits (score 150); all other classes score below 150.
  - Response: `digit` = 2, `max_score` = 150.
- Chunk boundaries:
  - Stimulus: class 9 weights = `features` with only bit 195 flipped; class 0 = `features` with bits 48 and 49 flipped; all others = `~features`.
  - Response: `digit` = 9, `max_score` = 195.
- Abort and restart:
  - Stimulus: drive `state` = `3'b000` at edge 20, then `3'b100` again.
  - Response: `done` stays 0 and `digit` is unchanged through the abort; the restart gives the correct result exactly 51 edges after re-entry.
- Async reset:
  - Stimulus: assert `rst_n` = 0 between clock edges mid-ACCUM, after a prior run left `digit` = 5 and `done` = 1.
  - Response: `done`, `digit` and `max_score` go to 0 immediately, without a clock edge; after release a full run completes in 51 edges.
